// File: rtl/mul10_pkg.sv
// Shared types and constants for the 10x10 multiply sequencer.
// Optional feature macro: MUL10_SEQ_ZERO_BYPASS_EN (zero-operand fast path).
package mul10_pkg;

  localparam int OP_W      = 10;
  localparam int PROD_W    = 20;
  // Widest request tag the request record can carry; TAG_W must not exceed it.
  localparam int TAG_MAX_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]      a;
    logic [OP_W-1:0]      b;
    logic [TAG_MAX_W-1:0] tag;
  } req_t;

endpackage

// File: rtl/mul10_sequencer_sync_fifo.sv
// Synchronous show-ahead FIFO: head entry is visible on rdata_o while not empty.
// Power-of-two DEPTH so pointers wrap by natural overflow; level_q tells full from empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage array: written at the tail, no reset needed since pointers gate validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop leaves level unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/mul10_sequencer.sv
// Request FIFO in front of an external karatsuba_10b multiplier: pops one
// request at a time, pulses start for START_CYCLES, waits for done, then
// presents the product with its tag until the consumer accepts it.
// Optional macro MUL10_SEQ_ZERO_BYPASS_EN: zero operands skip the multiplier.
module mul10_sequencer
  import mul10_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int START_CYCLES = 2,
  parameter int TAG_W        = 3,
  localparam int LVL_W       = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_s,
  output logic [TAG_W-1:0]  out_tag,
  output logic              mul_start,
  output logic [OP_W-1:0]   mul_a,
  output logic [OP_W-1:0]   mul_b,
  input  logic [PROD_W-1:0] mul_s,
  input  logic              mul_done,
  output logic [LVL_W-1:0]  level
);

  localparam int CNT_W = $clog2(START_CYCLES + 1);

  state_t             state_q;
  req_t               op_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               mul_start_q;
  logic               out_valid_q;
  logic [PROD_W-1:0]  out_s_q;
  logic [TAG_W-1:0]   out_tag_q;
  logic               ready_en_q;

  req_t               in_req;
  req_t               head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               zero_hit;

  assign in_req   = '{a: in_a, b: in_b, tag: TAG_MAX_W'(in_tag)};
  assign in_ready = ready_en_q && !fifo_full;
  assign push     = in_valid && in_ready;
  // Pop only from IDLE, so a freshly pushed entry is seen one cycle later at the earliest.
  assign pop      = (state_q == IDLE) && !fifo_empty;

`ifdef MUL10_SEQ_ZERO_BYPASS_EN
  assign zero_hit = (head.a == '0) || (head.b == '0);
`else
  assign zero_hit = 1'b0;
`endif

  sync_fifo #(
    .WIDTH ($bits(req_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (in_req),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  // Hold off in_ready until the first clock edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready_en_q <= 1'b0;
    else     ready_en_q <= 1'b1;
  end

  // Operation sequencer with all handshake and multiplier outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      cnt_q       <= '0;
      mul_start_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_s_q     <= '0;
      out_tag_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            op_q <= head;
            if (zero_hit) begin
              out_s_q     <= '0;
              out_tag_q   <= TAG_W'(head.tag);
              out_valid_q <= 1'b1;
              state_q     <= RESP;
            end else begin
              cnt_q       <= '0;
              mul_start_q <= 1'b1;
              state_q     <= START;
            end
          end
        end
        START: begin
          if (cnt_q == CNT_W'(START_CYCLES - 1)) begin
            mul_start_q <= 1'b0;
            state_q     <= WAIT;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        WAIT: begin
          if (mul_done) begin
            out_s_q     <= mul_s;
            out_tag_q   <= TAG_W'(op_q.tag);
            out_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Operands come straight from the operand register, stable from START through WAIT.
  assign mul_start = mul_start_q;
  assign mul_a     = op_q.a;
  assign mul_b     = op_q.b;
  assign out_valid = out_valid_q;
  assign out_s     = out_s_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_mul10_sequencer.sv
// Self-checking bench for mul10_sequencer with a behavioural multiplier model
// and an in-order scoreboard. Honours MUL10_SEQ_ZERO_BYPASS_EN when defined.
module tb_mul10_sequencer;

  localparam int DEPTH        = 4;
  localparam int START_CYCLES = 2;
  localparam int TAG_W        = 3;
  localparam int LVL_W        = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [9:0]        in_a;
  logic [9:0]        in_b;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [19:0]       out_s;
  logic [TAG_W-1:0]  out_tag;
  logic              mul_start;
  logic [9:0]        mul_a;
  logic [9:0]        mul_b;
  logic [19:0]       mul_s;
  logic              mul_done;
  logic [LVL_W-1:0]  level;

  mul10_sequencer #(
    .DEPTH        (DEPTH),
    .START_CYCLES (START_CYCLES),
    .TAG_W        (TAG_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_tag   (out_tag),
    .mul_start (mul_start),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_s     (mul_s),
    .mul_done  (mul_done),
    .level     (level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  // ---------------- behavioural karatsuba_10b model ----------------
  int        lat_min = 2;
  int        lat_max = 2;
  bit        m_busy  = 0;
  bit        m_prev  = 0;
  bit        m_track = 0;
  bit        m_fire;
  int        m_cnt;
  logic [9:0] m_a, m_b;

  initial begin
    mul_done = 1'b0;
    mul_s    = 20'h0;
  end

  // Latches operands on start, answers a*b after a random latency with a one-cycle done.
  always @(posedge clk) begin
    m_fire = 0;
    if (rst) m_track = 0;
    if (mul_start) begin
      if (m_prev && m_track) begin
        chk("mul_a_stable_start", 32'(mul_a), 32'(m_a));
        chk("mul_b_stable_start", 32'(mul_b), 32'(m_b));
      end
      m_busy  = 1;
      m_cnt   = $urandom_range(lat_max, lat_min);
      m_a     = mul_a;
      m_b     = mul_b;
      m_track = 1;
    end else if (m_busy) begin
      if (m_track && !rst) begin
        chk("mul_a_stable_wait", 32'(mul_a), 32'(m_a));
        chk("mul_b_stable_wait", 32'(mul_b), 32'(m_b));
      end
      if (m_cnt <= 1) begin
        m_fire = 1;
        m_busy = 0;
      end else begin
        m_cnt--;
      end
    end
    m_prev = mul_start;
    #1;
    mul_done = m_fire;
    mul_s    = m_fire ? (20'(m_a) * 20'(m_b)) : 20'hABCDE;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [19:0]      prod;
    logic [TAG_W-1:0] tag;
    int               nstart;
  } exp_t;

  exp_t exp_q[$];
  int   start_cnt = 0;
  int   n_acc = 0;
  int   n_res = 0;
  bit   hold_v = 0;
  logic [19:0]      hold_s;
  logic [TAG_W-1:0] hold_tag;

  always @(posedge clk) begin
    exp_t e;
    exp_t h;
    if (rst) begin
      hold_v    = 0;
      start_cnt = 0;
    end else begin
      if (mul_start) start_cnt++;
      if (hold_v) begin
        chk("out_valid_held", 32'(out_valid), 32'd1);
        chk("out_s_held", 32'(out_s), 32'(hold_s));
        chk("out_tag_held", 32'(out_tag), 32'(hold_tag));
      end
      if (in_valid && in_ready) begin
        e.prod = 20'(in_a) * 20'(in_b);
        e.tag  = in_tag;
`ifdef MUL10_SEQ_ZERO_BYPASS_EN
        e.nstart = (in_a == 10'd0 || in_b == 10'd0) ? 0 : START_CYCLES;
`else
        e.nstart = START_CYCLES;
`endif
        exp_q.push_back(e);
        n_acc++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          timeout_fail("unexpected_result");
        end else begin
          h = exp_q.pop_front();
          chk("sb_out_s", 32'(out_s), 32'(h.prod));
          chk("sb_out_tag", 32'(out_tag), 32'(h.tag));
          chk("sb_start_cycles", 32'(start_cnt), 32'(h.nstart));
          $display("result #%0d: s=%0d tag=%0d start_cycles=%0d", n_res, out_s, out_tag, start_cnt);
        end
        n_res++;
        start_cnt = 0;
      end
      hold_v   = out_valid && !out_ready;
      hold_s   = out_s;
      hold_tag = out_tag;
    end
  end

  // ---------------- stimulus helpers (called at negedge) ----------------
  task automatic push_req(input logic [9:0] a, input logic [9:0] b, input logic [TAG_W-1:0] t);
    bit ok;
    ok = 0;
    in_a = a; in_b = b; in_tag = t; in_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      ok = in_ready;
      @(negedge clk);
      if (ok) break;
    end
    if (!ok) timeout_fail("push_req");
  endtask

  task automatic wait_out(input int max_cyc);
    bit got;
    got = 0;
    for (int i = 0; i < max_cyc; i++) begin
      if (out_valid) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    if (!got) timeout_fail("wait_out");
  endtask

  task automatic wait_drain(input int max_cyc);
    bit done;
    done = 0;
    for (int i = 0; i < max_cyc; i++) begin
      if (exp_q.size() == 0 && !out_valid) begin
        done = 1;
        break;
      end
      @(negedge clk);
    end
    if (!done) timeout_fail("drain");
  endtask

  typedef struct {
    logic [9:0]       a;
    logic [9:0]       b;
    logic [TAG_W-1:0] tag;
    logic [19:0]      exp_s;
  } vec_t;

  vec_t vecs[6];
  bit   rand_ready = 0;

  always @(negedge clk) begin
    if (rand_ready) out_ready = ($urandom_range(3, 0) != 0);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int acc0, res0;

    vecs[0] = '{a: 10'd1023, b: 10'd1023, tag: 3'd5, exp_s: 20'd1046529};
    vecs[1] = '{a: 10'd0,    b: 10'd77,   tag: 3'd1, exp_s: 20'd0};
    vecs[2] = '{a: 10'd1,    b: 10'd1,    tag: 3'd2, exp_s: 20'd1};
    vecs[3] = '{a: 10'd512,  b: 10'd2,    tag: 3'd3, exp_s: 20'd1024};
    vecs[4] = '{a: 10'd1000, b: 10'd1000, tag: 3'd4, exp_s: 20'd1000000};
    vecs[5] = '{a: 10'd3,    b: 10'd7,    tag: 3'd6, exp_s: 20'd21};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_mul_start", 32'(mul_start), 32'd0);
    chk("rst_out_s", 32'(out_s), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_mul_a", 32'(mul_a), 32'd0);
    chk("rst_mul_b", 32'(mul_b), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_release", 32'(in_ready), 32'd1);

    // Table-driven single transactions.
    for (int i = 0; i < 6; i++) begin
      push_req(vecs[i].a, vecs[i].b, vecs[i].tag);
      in_valid = 1'b0;
      wait_out(100);
      chk("vec_out_s", 32'(out_s), 32'(vecs[i].exp_s));
      chk("vec_out_tag", 32'(out_tag), 32'(vecs[i].tag));
      $display("vector %0d: a=%0d b=%0d -> s=%0d tag=%0d", i, vecs[i].a, vecs[i].b, out_s, out_tag);
      @(negedge clk);
    end

    // Zero operand: latency from acceptance to out_valid.
    push_req(10'd0, 10'd77, 3'd7);
    in_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
`ifdef MUL10_SEQ_ZERO_BYPASS_EN
    chk("bypass_latency", 32'(k), 32'd2);
`endif
    chk("zero_out_s", 32'(out_s), 32'd0);
    $display("zero operand: out_valid after %0d cycles, s=%0d", k, out_s);
    @(negedge clk);

    // Fill the FIFO behind a held result.
    out_ready = 1'b0;
    push_req(10'd5, 10'd6, 3'd0);
    in_valid = 1'b0;
    wait_out(100);
    for (int i = 0; i < 4; i++) push_req(10'(i + 10), 10'(i + 20), 3'(i + 1));
    in_valid = 1'b0;
    chk("full_level", 32'(level), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    repeat (5) @(negedge clk);
    chk("held_out_valid", 32'(out_valid), 32'd1);
    chk("held_out_s", 32'(out_s), 32'd30);
    chk("held_level", 32'(level), 32'd4);
    $display("full fifo: level=%0d in_ready=%0d held s=%0d", level, in_ready, out_s);
    out_ready = 1'b1;
    wait_drain(300);

    // Reset during WAIT with three entries queued.
    lat_min = 8; lat_max = 8;
    for (int i = 0; i < 4; i++) push_req(10'(i + 100), 10'(i + 3), 3'(i));
    in_valid = 1'b0;
    chk("pre_rst_level", 32'(level), 32'd3);
    chk("pre_rst_mul_start", 32'(mul_start), 32'd0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_mul_start", 32'(mul_start), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_mul_a", 32'(mul_a), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("stray_done_out_valid", 32'(out_valid), 32'd0);
    chk("stray_done_level", 32'(level), 32'd0);
    lat_min = 2; lat_max = 2;
    push_req(10'd37, 10'd41, 3'd2);
    in_valid = 1'b0;
    wait_out(100);
    chk("post_rst_out_s", 32'(out_s), 32'd1517);
    $display("after reset: s=%0d tag=%0d", out_s, out_tag);
    @(negedge clk);
    wait_drain(50);

    // Randomised traffic with output stalls.
    acc0 = n_acc; res0 = n_res;
    lat_min = 1; lat_max = 4;
    rand_ready = 1;
    for (int i = 0; i < 1000; i++) begin
      logic [9:0] ra, rb;
      ra = ($urandom_range(7, 0) == 0) ? 10'd0 : 10'($urandom);
      rb = ($urandom_range(7, 0) == 0) ? 10'd0 : 10'($urandom);
      if ($urandom_range(3, 0) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      push_req(ra, rb, 3'(i));
    end
    in_valid = 1'b0;
    wait_drain(3000);
    rand_ready = 0;
    out_ready = 1'b1;
    chk("random_accepted", 32'(n_acc - acc0), 32'd1000);
    chk("random_results", 32'(n_res - res0), 32'd1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
